// File: rtl/vga_pattern_sequencer_module.sv
// Test-pattern sequencer: chooses which pattern the colour datapath shows. Changes
// happen only at end of frame, either by auto-cycling or by a latched host request.
module vga_pattern_sequencer_module #(
  parameter int unsigned H_ACTIVE    = 800,
  parameter int unsigned V_ACTIVE    = 600,
  parameter int unsigned HOLD_FRAMES = 60
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic        Ready_Sig,
  input  logic [10:0] Column_Addr_Sig,
  input  logic [10:0] Row_Addr_Sig,
  input  logic        Auto_En_Sig,
  input  logic        Mode_Req_Sig,
  input  logic [1:0]  Mode_Sel_Sig,
  output logic [1:0]  Pattern_Sig,
  output logic        Mode_Ack_Sig,
  output logic        Frame_Start_Sig,
  output logic [7:0]  Frame_Cnt_Sig
);

  localparam logic [10:0] HLast    = 11'(H_ACTIVE - 1);
  localparam logic [10:0] VLast    = 11'(V_ACTIVE - 1);
  localparam logic [7:0]  HoldLast = 8'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {StSync, StAuto, StManual} state_e;

  state_e     state_q;
  logic       pending_q;
  logic [1:0] sel_q;
  logic       req_prev_q;
  logic       frame_end;
  logic       req_rise;

  assign frame_end = Ready_Sig && (Column_Addr_Sig == HLast) && (Row_Addr_Sig == VLast);
  assign req_rise  = Mode_Req_Sig && !req_prev_q;

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_q         <= StSync;
      pending_q       <= 1'b0;
      sel_q           <= 2'd0;
      req_prev_q      <= 1'b0;
      Pattern_Sig     <= 2'd0;
      Mode_Ack_Sig    <= 1'b0;
      Frame_Start_Sig <= 1'b0;
      Frame_Cnt_Sig   <= 8'd0;
    end else begin
      req_prev_q      <= Mode_Req_Sig;
      Frame_Start_Sig <= frame_end;
      Mode_Ack_Sig    <= 1'b0;

      if (frame_end) begin
        // A pending request always wins over auto-advance for this frame.
        if (pending_q) begin
          Pattern_Sig  <= sel_q;
          Mode_Ack_Sig <= 1'b1;
          pending_q    <= 1'b0;
        end
        case (state_q)
          StSync: begin
            state_q       <= Auto_En_Sig ? StAuto : StManual;
            Frame_Cnt_Sig <= 8'd0;
          end
          StAuto: begin
            if (!Auto_En_Sig) begin
              state_q       <= StManual;
              Frame_Cnt_Sig <= 8'd0;
            end else if (pending_q) begin
              Frame_Cnt_Sig <= 8'd0;
            end else if (Frame_Cnt_Sig == HoldLast) begin
              Pattern_Sig   <= Pattern_Sig + 2'd1;
              Frame_Cnt_Sig <= 8'd0;
            end else begin
              Frame_Cnt_Sig <= Frame_Cnt_Sig + 8'd1;
            end
          end
          StManual: begin
            if (Auto_En_Sig) begin
              state_q       <= StAuto;
              Frame_Cnt_Sig <= 8'd0;
            end else if (pending_q) begin
              Frame_Cnt_Sig <= 8'd0;
            end else if (Frame_Cnt_Sig != 8'hFF) begin
              Frame_Cnt_Sig <= Frame_Cnt_Sig + 8'd1;
            end
          end
          default: state_q <= StSync;
        endcase
      end

      // A rise on a frame_end cycle is latched here and applied at the following frame_end.
      if (req_rise && !pending_q) begin
        pending_q <= 1'b1;
        sel_q     <= Mode_Sel_Sig;
      end
    end
  end

endmodule

// File: doc/vga_pattern_sequencer_module.md
VGA_PATTERN_SEQUENCER_MODULE -- requirements
Module: vga_pattern_sequencer_module

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- H_ACTIVE, 800, active columns per line.
- V_ACTIVE, 600, active rows per frame.
- HOLD_FRAMES, 60, frames each pattern is shown in auto mode (2..256).

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- vga_clk, in, 1, sole clock, all logic on rising edge.
- rst, in, 1, synchronous active-high reset.
- Ready_Sig, in, 1, active-video qualifier from the sync generator.
- Column_Addr_Sig, in, 11, current pixel column.
- Row_Addr_Sig, in, 11, current pixel row.
- Auto_En_Sig, in, 1, 1 = auto pattern cycling, 0 = manual hold.
- Mode_Req_Sig, in, 1, host pattern-change request (level; rising edge is the request).
- Mode_Sel_Sig, in, 2, requested pattern, sampled on the Mode_Req_Sig rising edge.
- Pattern_Sig, out, 2, pattern index to the colour datapath.
- Mode_Ack_Sig, out, 1, one-cycle pulse when the requested pattern takes effect.
- Frame_Start_Sig, out, 1, one-cycle pulse the cycle after the last active pixel.
- Frame_Cnt_Sig, out, 8, frames shown since the last pattern change.

Function
REQ-003 The block SHALL define frame_end as Ready_Sig=1 AND Column_Addr_Sig=H_ACTIVE-1 AND Row_Addr_Sig=V_ACTIVE-1, evaluated combinationally from the inputs.
REQ-004 While Ready_Sig=0, frame_end SHALL be 0 regardless of the address values.
REQ-005 Frame_Start_Sig SHALL equal frame_end registered, i.e. a pulse exactly 1 cycle later.
REQ-006 The FSM SHALL have three states: SYNC (after reset), AUTO and MANUAL.
- SYNC goes to AUTO at the first frame_end if Auto_En_Sig=1, otherwise to MANUAL.
REQ-007 The block SHALL sample Auto_En_Sig only at frame_end.
- AUTO goes to MANUAL when Auto_En_Sig=0.
- MANUAL goes to AUTO when Auto_En_Sig=1.
- On any AUTO or MANUAL transition, Frame_Cnt_Sig SHALL be cleared to 0.
REQ-008 Pattern_Sig and Frame_Cnt_Sig SHALL change only on the clock edge at which frame_end=1, or at reset, so that a pattern never changes mid-frame.
REQ-009 In AUTO at frame_end with no pending request:
- If Frame_Cnt_Sig=HOLD_FRAMES-1, Pattern_Sig SHALL increment modulo 4 (3 wraps to 0) and Frame_Cnt_Sig SHALL clear to 0.
- Otherwise, Frame_Cnt_Sig SHALL increment by 1.
REQ-010 In MANUAL at frame_end with no pending request:
- Pattern_Sig SHALL hold.
- Frame_Cnt_Sig SHALL increment, saturating at 255.
REQ-011 In SYNC, frame_end SHALL leave Pattern_Sig unchanged and Frame_Cnt_Sig at 0.
REQ-012 A Mode_Req_Sig rising edge, detected against its registered previous value, SHALL be accepted only when no request is pending.
- On acceptance, the block SHALL latch Mode_Sel_Sig and set pending.
REQ-013 Rising edges while a request is pending SHALL be ignored; the first accepted request wins.
REQ-014 At the first frame_end strictly after acceptance, in any state:
- Pattern_Sig SHALL load the latched value.
- Frame_Cnt_Sig SHALL clear to 0.
- Mode_Ack_Sig SHALL pulse high for exactly that one cycle (registered, on the same edge).
- Pending SHALL clear.
REQ-015 A request accepted on the same cycle as frame_end SHALL be applied at the next frame_end, not the current one.
REQ-016 When a pending request and an auto-advance coincide at frame_end, the request SHALL win and no auto increment SHALL occur.
REQ-017 When a pending request and an AUTO or MANUAL transition coincide at frame_end:
- Both SHALL take effect.
- Frame_Cnt_Sig SHALL be 0.
REQ-018 Loading the pattern already displayed SHALL still clear Frame_Cnt_Sig and pulse Mode_Ack_Sig.
REQ-019 Mode_Req_Sig held high after the ack SHALL NOT generate a new request; it must return low for at least 1 cycle first.

Reset
REQ-020 When rst=1 at a clock edge, the block SHALL set:
- Pattern_Sig=0, Mode_Ack_Sig=0, Frame_Start_Sig=0, Frame_Cnt_Sig=0.
- State SYNC, pending cleared, registered Mode_Req_Sig previous value cleared to 0.
REQ-021 Reset asserted mid-operation SHALL drop any pending request with no Mode_Ack_Sig pulse.
REQ-022 Reset SHALL take priority over frame_end in the same cycle.

Verification
All scenarios use H_ACTIVE=4, V_ACTIVE=3, HOLD_FRAMES=2.
REQ-023 The bench SHALL cover auto cycling:
- Stimulus: Auto_En_Sig=1, 9 frames.
- Response: after SYNC, Pattern_Sig runs 0,0,1,1,2,2,3,3,0 per frame, and Frame_Start_Sig pulses once per frame.
REQ-024 The bench SHALL cover a manual request:
- Stimulus: Auto_En_Sig=0; a Mode_Req_Sig rise with Mode_Sel_Sig=2 mid-frame.
- Response: Pattern_Sig=2 and Mode_Ack_Sig=1 for 1 cycle, both at the next frame_end edge; Frame_Cnt_Sig=0.
REQ-025 The bench SHALL cover a request/auto collision:
- Stimulus: in AUTO with Frame_Cnt_Sig=1 and Pattern_Sig=1, request Mode_Sel_Sig=0.
- Response: at frame_end, Pattern_Sig=0 (not 2) and Frame_Cnt_Sig=0.
REQ-026 The bench SHALL cover a double request:
- Stimulus: request Mode_Sel_Sig=3, drop Req, then request Mode_Sel_Sig=1, all within the same frame.
- Response: Pattern_Sig=3 with a single ack; the second request is lost.
REQ-027 The bench SHALL cover Ready_Sig gating:
- Stimulus: addresses at (3,2) with Ready_Sig=0.
- Response: no Frame_Start_Sig pulse and no counter change.
REQ-028 The bench SHALL cover reset with a pending request:
- Stimulus: rst=1 for 1 cycle while a request is pending.
- Response: all outputs 0 and no ack at the following frame_end.
